anc_mc_sched: RTL and testbench
===============================

ANC_MC_SCHED -- requirements
Module: anc_mc_sched

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent ANC channels sharing one FIR/LMS engine.
REQ-002 SHALL have parameter DW, default 16: signed sample width.
REQ-003 SHALL have parameter TMO, default 1024: maximum engine wait in cycles before abort.
REQ-004 SHALL define CW as clog2(NCH), minimum 1: channel-index width.
REQ-005 Clock and reset:
- clk  in  1  the only clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-006 Control inputs:
- init_done  in  1  grant enable.
- bypass_mode_sel  in  1  forces weight adjust to zero.
REQ-007 Per-channel input handshake:
- in_valid  in  NCH  per-channel sample valid.
- in_ready  out  NCH  per-channel slot free.
REQ-008 Packed per-channel sample inputs; channel c occupies bits [c*DW +: DW]:
- x_in  in  NCH*DW  reference sample.
- a_in  in  NCH*DW  desired sample.
- e_in  in  NCH*DW  error sample.
REQ-009 Shared step size: u_in  in  DW  signed LMS step size, Q1.15.
REQ-010 Engine request outputs:
- eng_go  out  1  one-cycle engine start.
- eng_ch  out  CW  channel being processed.
- eng_x, eng_a  out  DW each  operands.
- eng_wadj  out  DW  weight adjust.
REQ-011 Engine response inputs:
- eng_done  in  1  engine finished.
- eng_y  in  DW  engine result.
REQ-012 Result and status outputs:
- out_valid  out  1  result strobe.
- out_ch  out  CW  result channel.
- out_sample  out  DW  result.
- busy  out  1  FSM not IDLE.
- err  out  1  sticky timeout flag.

Function
REQ-013 Each channel SHALL own a one-entry slot holding x, a and e plus a full flag; in_ready[c] SHALL equal NOT full[c].
REQ-014 Capture: when in_valid[c] and in_ready[c] are both high, the slot SHALL load channel c's fields and set full[c] on the same edge; in_valid while full SHALL be ignored, with no overwrite.
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and EMIT.
REQ-016 IDLE: when init_done is high and any slot is full, the FSM SHALL grant the first full channel searching round-robin from rr_ptr, wrapping NCH-1 to 0, and go to ISSUE.
REQ-017 ISSUE, exactly one cycle:
- eng_go=1; eng_ch/eng_x/eng_a/eng_wadj from the granted slot.
- Clear full[granted]; rr_ptr = (granted+1) mod NCH.
- Go to WAIT.
REQ-018 eng_x, eng_a and eng_wadj SHALL hold their ISSUE values until the next ISSUE.
REQ-019 WAIT: on eng_done, register eng_y and go to EMIT; eng_done in any other state SHALL be ignored.
REQ-020 EMIT: out_valid=1 for one cycle with out_ch=granted and out_sample=registered eng_y, then go to IDLE; out_ch/out_sample SHALL hold between strobes.
REQ-021 Timeout: a WAIT counter reset on ISSUE; reaching TMO cycles without eng_done SHALL abort to IDLE with no out_valid and set err; the sample is dropped.
REQ-022 Weight adjust: 2*DW-bit signed product u_in*e; arithmetic shift right DW-1; saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 bypass_mode_sel=1 in ISSUE SHALL force eng_wadj=0; eng_x/eng_a are unaffected.
REQ-024 init_done low SHALL block new grants only; captures and an in-flight operation continue.
REQ-025 Latency: capture edge T gives eng_go at T+2; eng_done at cycle D gives out_valid at D+1; minimum capture-to-out_valid is 4 cycles with same-cycle eng_done.
REQ-026 A slot cleared in ISSUE SHALL accept a new capture from the next cycle.
REQ-027 busy SHALL be high in ISSUE, WAIT and EMIT.

Reset
REQ-028 rst_n low SHALL asynchronously force:
- State IDLE; all full=0, so in_ready all 1.
- rr_ptr=0; timeout counter=0.
- eng_go=0; out_valid=0; busy=0; err=0.
- eng_ch, eng_x, eng_a, eng_wadj, out_ch, out_sample = 0.
REQ-029 Reset asserted mid-WAIT SHALL discard the operation; a late eng_done after release SHALL be ignored.
REQ-030 err SHALL clear only by reset.

Verification
REQ-031 Single channel, NCH=4, init_done=1: ch2 x=0x0100, a=0x0200, e=0x4000, u=0x4000 -> eng_go 2 cycles later with eng_ch=2 and eng_wadj=0x2000; eng_done with eng_y=0x1234 -> out_valid next cycle, out_ch=2, out_sample=0x1234.
REQ-032 All four channels captured the same cycle, rr_ptr=0 -> grant order 0,1,2,3; then ch1 and ch3 refilled -> order 1,3.
REQ-033 Saturation: u=0x8000, e=0x8000 -> eng_wadj=0x7FFF; same stimulus with bypass_mode_sel=1 -> eng_wadj=0x0000.
REQ-034 Backpressure: ch0 full, in_valid[0] held high with a new x -> in_ready[0]=0 and slot unchanged until its ISSUE; in_ready[0]=1 the following cycle.
REQ-035 TMO=16, eng_done never asserted -> FSM returns to IDLE 16 cycles after ISSUE, err=1, no out_valid, next full channel granted.
REQ-036 Reset pulsed during WAIT, then eng_done -> no out_valid, all in_ready=1, busy=0.

Source files
------------

// File: rtl/anc_mc_sched.sv
// ---------------------------------------------------------------------------
// anc_mc_sched
// Multi-channel scheduler that time-shares one FIR/LMS engine between NCH
// independent ANC channels. Every channel has a one-entry sample slot
// {x, a, e}. A four-state FSM picks the next full slot round-robin, issues it
// to the engine together with a saturated LMS weight adjust (u * e), waits
// for the engine result and emits it. An engine that never answers is
// abandoned after TMO cycles and flagged in a sticky err bit.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   init_done                   enables new grants
//   bypass_mode_sel             forces the issued weight adjust to zero
//   in_valid/in_ready [NCH]     per-channel capture handshake
//   x_in/a_in/e_in [NCH*DW]     packed per-channel samples, ch c at [c*DW +: DW]
//   u_in [DW]                   shared signed Q1.15 LMS step size
//   eng_go/eng_ch/eng_x/eng_a/eng_wadj   engine request
//   eng_done/eng_y              engine response
//   out_valid/out_ch/out_sample result strobe
//   busy, err                   FSM active, sticky timeout flag
// ---------------------------------------------------------------------------
module anc_mc_sched #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int TMO = 1024,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              bypass_mode_sel,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH*DW-1:0] x_in,
    input  logic [NCH*DW-1:0] a_in,
    input  logic [NCH*DW-1:0] e_in,
    input  logic [DW-1:0]     u_in,
    output logic              eng_go,
    output logic [CW-1:0]     eng_ch,
    output logic [DW-1:0]     eng_x,
    output logic [DW-1:0]     eng_a,
    output logic [DW-1:0]     eng_wadj,
    input  logic              eng_done,
    input  logic [DW-1:0]     eng_y,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic [DW-1:0]     out_sample,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(TMO + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    localparam logic signed [2*DW-1:0] WADJ_MAX = (2*DW)'((1 << (DW - 1)) - 1);
    localparam logic signed [2*DW-1:0] WADJ_MIN = ~WADJ_MAX;

    // (u * e) >>> (DW-1), clipped to the signed DW-bit range. Only the
    // (-1.0 * -1.0) corner can overflow, but both limits are checked.
    function automatic logic [DW-1:0] calc_wadj(input logic signed [DW-1:0] u,
                                                input logic signed [DW-1:0] e);
        logic signed [2*DW-1:0] prod;
        logic signed [2*DW-1:0] shr;
        prod = (2*DW)'(u) * (2*DW)'(e);
        shr  = prod >>> (DW - 1);
        if (shr > WADJ_MAX) begin
            calc_wadj = WADJ_MAX[DW-1:0];
        end else if (shr < WADJ_MIN) begin
            calc_wadj = WADJ_MIN[DW-1:0];
        end else begin
            calc_wadj = shr[DW-1:0];
        end
    endfunction

    logic [1:0]    state_q, state_d;
    logic [NCH-1:0] full_q, full_d;
    logic [DW-1:0] x_q [NCH];
    logic [DW-1:0] a_q [NCH];
    logic [DW-1:0] e_q [NCH];
    logic [DW-1:0] x_d [NCH];
    logic [DW-1:0] a_d [NCH];
    logic [DW-1:0] e_d [NCH];
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          eng_go_q, eng_go_d;
    logic [CW-1:0] eng_ch_q, eng_ch_d;
    logic [DW-1:0] eng_x_q, eng_x_d;
    logic [DW-1:0] eng_a_q, eng_a_d;
    logic [DW-1:0] eng_wadj_q, eng_wadj_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic [DW-1:0] out_sample_q, out_sample_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          grant_found_s;
    logic [CW-1:0] grant_ch_s;
    logic [CW:0]   rr_idx_s;
    logic          clear_s;

    // Round-robin search: first full slot starting at rr_ptr, wrapping at NCH.
    always_comb begin
        grant_found_s = 1'b0;
        grant_ch_s    = '0;
        rr_idx_s      = '0;
        for (int i = 0; i < NCH; i++) begin
            rr_idx_s = {1'b0, rr_ptr_q} + (CW+1)'(i);
            if (rr_idx_s >= (CW+1)'(NCH)) begin
                rr_idx_s = rr_idx_s - (CW+1)'(NCH);
            end else begin
                rr_idx_s = rr_idx_s;
            end
            if (!grant_found_s && full_q[rr_idx_s[CW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_ch_s    = rr_idx_s[CW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Scheduler FSM and engine/result register next-state logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        tmo_cnt_d    = tmo_cnt_q;
        eng_go_d     = 1'b0;
        eng_ch_d     = eng_ch_q;
        eng_x_d      = eng_x_q;
        eng_a_d      = eng_a_q;
        eng_wadj_d   = eng_wadj_q;
        out_valid_d  = 1'b0;
        out_ch_d     = out_ch_q;
        out_sample_d = out_sample_q;
        err_d        = err_q;
        clear_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Engine request registers load on entry to ISSUE so that
                // eng_go and its operands are flop outputs during ISSUE.
                if (init_done && grant_found_s) begin
                    state_d    = ST_ISSUE;
                    eng_go_d   = 1'b1;
                    eng_ch_d   = grant_ch_s;
                    eng_x_d    = x_q[grant_ch_s];
                    eng_a_d    = a_q[grant_ch_s];
                    eng_wadj_d = bypass_mode_sel ? {DW{1'b0}}
                                                 : calc_wadj($signed(u_in), $signed(e_q[grant_ch_s]));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                clear_s   = 1'b1;
                tmo_cnt_d = '0;
                if (eng_ch_q == CW'(NCH - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = eng_ch_q + CW'(1);
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    state_d      = ST_EMIT;
                    out_valid_d  = 1'b1;
                    out_ch_d     = eng_ch_q;
                    out_sample_d = eng_y;
                end else if (tmo_cnt_q == TW'(TMO - 1)) begin
                    // TMO cycles spent in WAIT: drop the sample.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Slot capture and release; capture only into an empty slot.
    always_comb begin
        full_d = full_q;
        for (int c = 0; c < NCH; c++) begin
            x_d[c] = x_q[c];
            a_d[c] = a_q[c];
            e_d[c] = e_q[c];
            if (in_valid[c] && !full_q[c]) begin
                x_d[c]    = x_in[c*DW +: DW];
                a_d[c]    = a_in[c*DW +: DW];
                e_d[c]    = e_in[c*DW +: DW];
                full_d[c] = 1'b1;
            end else begin
                full_d[c] = full_d[c];
            end
        end
        if (clear_s) begin
            full_d[eng_ch_q] = 1'b0;
        end else begin
            full_d = full_d;
        end
    end

    // State, slot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            full_q       <= '0;
            rr_ptr_q     <= '0;
            tmo_cnt_q    <= '0;
            eng_go_q     <= 1'b0;
            eng_ch_q     <= '0;
            eng_x_q      <= '0;
            eng_a_q      <= '0;
            eng_wadj_q   <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                x_q[c] <= '0;
                a_q[c] <= '0;
                e_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            rr_ptr_q     <= rr_ptr_d;
            tmo_cnt_q    <= tmo_cnt_d;
            eng_go_q     <= eng_go_d;
            eng_ch_q     <= eng_ch_d;
            eng_x_q      <= eng_x_d;
            eng_a_q      <= eng_a_d;
            eng_wadj_q   <= eng_wadj_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_sample_q <= out_sample_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            for (int c = 0; c < NCH; c++) begin
                x_q[c] <= x_d[c];
                a_q[c] <= a_d[c];
                e_q[c] <= e_d[c];
            end
        end
    end

    assign in_ready   = ~full_q;
    assign eng_go     = eng_go_q;
    assign eng_ch     = eng_ch_q;
    assign eng_x      = eng_x_q;
    assign eng_a      = eng_a_q;
    assign eng_wadj   = eng_wadj_q;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_sample = out_sample_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_anc_mc_sched.sv
// ---------------------------------------------------------------------------
// tb_anc_mc_sched
// Directed bench for anc_mc_sched (NCH=4, DW=16, TMO=16). Single-channel
// transactions come from a table of hand-computed vectors; round-robin
// order, backpressure, timeout and reset-during-WAIT are hand-written
// sequences. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_anc_mc_sched;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int TMO = 16;

    logic              clk;
    logic              rst_n;
    logic              init_done;
    logic              bypass_mode_sel;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*DW-1:0] x_in;
    logic [NCH*DW-1:0] a_in;
    logic [NCH*DW-1:0] e_in;
    logic [DW-1:0]     u_in;
    logic              eng_go;
    logic [1:0]        eng_ch;
    logic [DW-1:0]     eng_x;
    logic [DW-1:0]     eng_a;
    logic [DW-1:0]     eng_wadj;
    logic              eng_done;
    logic [DW-1:0]     eng_y;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_sample;
    logic              busy;
    logic              err;

    anc_mc_sched #(.NCH(NCH), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .bypass_mode_sel(bypass_mode_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .a_in(a_in), .e_in(e_in), .u_in(u_in),
        .eng_go(eng_go), .eng_ch(eng_ch), .eng_x(eng_x), .eng_a(eng_a),
        .eng_wadj(eng_wadj), .eng_done(eng_done), .eng_y(eng_y),
        .out_valid(out_valid), .out_ch(out_ch), .out_sample(out_sample),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int          ch;
        logic [15:0] x;
        logic [15:0] a;
        logic [15:0] e;
        logic [15:0] u;
        logic        byp;
        logic [15:0] y;
        logic [15:0] wadj;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_go(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (eng_go === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits for the next grant, answers it immediately and checks the result.
    task automatic run_txn(input int exp_ch, input logic [15:0] exp_x, input logic [15:0] y);
        bit ok;
        wait_go(20, ok);
        chk("go_seen", 32'(ok), 32'd1);
        chk("grant_ch", 32'(eng_ch), 32'(exp_ch));
        chk("grant_x", 32'(eng_x), 32'(exp_x));
        @(negedge clk);
        eng_done = 1'b1;
        eng_y    = y;
        @(negedge clk);
        eng_done = 1'b0;
        chk("txn_valid", 32'(out_valid), 32'd1);
        chk("txn_ch", 32'(out_ch), 32'(exp_ch));
        chk("txn_sample", 32'(out_sample), 32'(y));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit ok;
        bit seen_ov;

        //            ch  x        a        e        u        byp   y        wadj
        vecs[0] = '{2, 16'h0100, 16'h0200, 16'h4000, 16'h4000, 1'b0, 16'h1234, 16'h2000};
        vecs[1] = '{0, 16'h0A0A, 16'h0B0B, 16'h8000, 16'h8000, 1'b0, 16'h4321, 16'h7FFF};
        vecs[2] = '{1, 16'h0C0C, 16'h0D0D, 16'h8000, 16'h8000, 1'b1, 16'hBEEF, 16'h0000};
        vecs[3] = '{3, 16'h1111, 16'h2222, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 16'h8001};
        vecs[4] = '{0, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 16'h8001};
        vecs[5] = '{1, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 16'h8000, 16'hFFFF};
        vecs[6] = '{2, 16'h1357, 16'h2468, 16'h1000, 16'h2000, 1'b0, 16'h5A5A, 16'h0400};
        vecs[7] = '{3, 16'h0F0F, 16'hF0F0, 16'h4000, 16'hC000, 1'b0, 16'hA5A5, 16'hE000};

        rst_n = 1'b0; init_done = 1'b1; bypass_mode_sel = 1'b0;
        in_valid = '0; x_in = '0; a_in = '0; e_in = '0; u_in = '0;
        eng_done = 1'b0; eng_y = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_eng_go", 32'(eng_go), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_eng_regs", {eng_x, eng_wadj}, 32'd0);
        chk("rst_out_regs", {14'd0, out_ch, out_sample}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single-channel transactions
        for (int i = 0; i < 8; i++) begin
            x_in = '0; a_in = '0; e_in = '0;
            x_in[vecs[i].ch*DW +: DW] = vecs[i].x;
            a_in[vecs[i].ch*DW +: DW] = vecs[i].a;
            e_in[vecs[i].ch*DW +: DW] = vecs[i].e;
            u_in = vecs[i].u;
            bypass_mode_sel = vecs[i].byp;
            in_valid = 4'b0001 << vecs[i].ch;
            @(negedge clk);
            in_valid = '0;
            chk("vec_ready_lo", 32'(in_ready[vecs[i].ch]), 32'd0);
            chk("vec_go_early", 32'(eng_go), 32'd0);
            @(negedge clk);
            chk("vec_go", 32'(eng_go), 32'd1);
            chk("vec_ch", 32'(eng_ch), 32'(vecs[i].ch));
            chk("vec_x", 32'(eng_x), 32'(vecs[i].x));
            chk("vec_a", 32'(eng_a), 32'(vecs[i].a));
            chk("vec_wadj", 32'(eng_wadj), 32'(vecs[i].wadj));
            @(negedge clk);
            chk("vec_go_one_cycle", 32'(eng_go), 32'd0);
            chk("vec_no_early_out", 32'(out_valid), 32'd0);
            eng_done = 1'b1;
            eng_y    = vecs[i].y;
            @(negedge clk);
            eng_done = 1'b0;
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_out_ch", 32'(out_ch), 32'(vecs[i].ch));
            chk("vec_out_sample", 32'(out_sample), 32'(vecs[i].y));
            chk("vec_wadj_hold", 32'(eng_wadj), 32'(vecs[i].wadj));
            @(negedge clk);
            chk("vec_out_pulse", 32'(out_valid), 32'd0);
            chk("vec_sample_hold", 32'(out_sample), 32'(vecs[i].y));
            chk("vec_idle", 32'(busy), 32'd0);
        end
        bypass_mode_sel = 1'b0;
        u_in = 16'h4000;

        // Round-robin from rr_ptr=0 with all four slots full
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        x_in = {16'h0043, 16'h0032, 16'h0021, 16'h0010};
        in_valid = 4'hF;
        @(negedge clk);
        in_valid = '0;
        chk("rr_all_full", 32'(in_ready), 32'h0);
        run_txn(0, 16'h0010, 16'h1000);
        run_txn(1, 16'h0021, 16'h1001);
        run_txn(2, 16'h0032, 16'h1002);
        run_txn(3, 16'h0043, 16'h1003);
        x_in = {16'h00A3, 16'h0000, 16'h00A1, 16'h0000};
        in_valid = 4'b1010;
        @(negedge clk);
        in_valid = '0;
        run_txn(1, 16'h00A1, 16'h2001);
        run_txn(3, 16'h00A3, 16'h2003);

        // Backpressure on ch0 with grants held off by init_done
        init_done = 1'b0;
        x_in = '0;
        x_in[15:0] = 16'h1111;
        in_valid = 4'b0001;
        @(negedge clk);
        chk("bp_ready_lo", 32'(in_ready[0]), 32'd0);
        x_in[15:0] = 16'h2222;
        repeat (3) @(negedge clk);
        chk("bp_no_grant", 32'(busy), 32'd0);
        chk("bp_still_full", 32'(in_ready[0]), 32'd0);
        init_done = 1'b1;
        wait_go(20, ok);
        chk("bp_go_seen", 32'(ok), 32'd1);
        chk("bp_slot_kept", 32'(eng_x), 32'h1111);
        chk("bp_ready_in_issue", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        chk("bp_ready_after_issue", 32'(in_ready[0]), 32'd1);
        eng_done = 1'b1;
        eng_y = 16'h0BEE;
        @(negedge clk);
        eng_done = 1'b0;
        in_valid = '0;
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_recaptured", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        run_txn(0, 16'h2222, 16'h0C0E);

        // Timeout: rr_ptr now 1, so ch2 wins over ch0
        x_in = {16'h0000, 16'h0D02, 16'h0000, 16'h0D00};
        in_valid = 4'b0101;
        @(negedge clk);
        in_valid = '0;
        wait_go(20, ok);
        chk("tmo_go_seen", 32'(ok), 32'd1);
        chk("tmo_rr_ch", 32'(eng_ch), 32'd2);
        cnt = 0;
        seen_ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_ov = 1'b1;
            if (busy !== 1'b1) break;
            cnt++;
        end
        chk("tmo_wait_cycles", 32'(cnt), 32'(TMO));
        chk("tmo_no_out_valid", 32'(seen_ov), 32'd0);
        chk("tmo_err_set", 32'(err), 32'd1);
        run_txn(0, 16'h0D00, 16'h7777);
        chk("tmo_err_sticky", 32'(err), 32'd1);

        // Reset during WAIT, then a late eng_done
        x_in = {16'h0E03, 48'h0};
        in_valid = 4'b1000;
        @(negedge clk);
        in_valid = '0;
        wait_go(20, ok);
        chk("rw_go_seen", 32'(ok), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        eng_done = 1'b1;
        eng_y = 16'h5555;
        @(negedge clk);
        eng_done = 1'b0;
        chk("rw_no_out_valid", 32'(out_valid), 32'd0);
        chk("rw_in_ready", 32'(in_ready), 32'hF);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_err_cleared", 32'(err), 32'd0);
        @(negedge clk);
        chk("rw_still_quiet", 32'({out_valid, busy, eng_go}), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
